// File: rtl/array_proc_pkg.sv
// Shared definitions for the byte-array writer/reader pair.
// Holds the FSM state encoding and the default word width and frame depth,
// so both sides of the array agree on them.
package array_proc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/array_store_regs.sv
// DEPTH x DATA_W register array used as the frame buffer.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write word
//   raddr  in  read address (asynchronous read)
//   rdata  out word at raddr, combinational
// Contents are deliberately not reset; the reader never exposes a location
// before it has been written in the current frame.
module array_store_regs
  import array_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port into the register array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/array_frame_reader.sv
// Captures a frame of up to DEPTH words, replays it in write order over a
// valid/ready stream, then publishes the unsigned sum of the frame.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   wr_valid/wr_data/wr_ready   write stream (ready only while filling)
//   flush            close a partial frame and start draining it
//   rd_valid/rd_data/rd_ready/rd_last   read stream (valid only while draining)
//   frame_sum        sum of the last fully drained frame
//   frame_sum_valid  one-cycle pulse when frame_sum updates
//   count            unread words held (0..DEPTH)
module array_frame_reader
  import array_proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int SUM_W  = DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [SUM_W-1:0]  frame_sum,
  output logic              frame_sum_valid,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    frame_len_q, frame_len_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [SUM_W-1:0]   frame_sum_q, frame_sum_d;
  logic               frame_sum_valid_q, frame_sum_valid_d;

  logic               wr_hs;
  logic               rd_hs;
  logic [ADDR_W:0]    count_post;
  logic               mem_we;

  assign wr_ready = (state_q == ST_FILL);
  assign rd_valid = (state_q == ST_DRAIN);
  assign wr_hs    = wr_valid && wr_ready;
  assign rd_hs    = rd_valid && rd_ready;
  assign rd_last  = rd_valid && ({1'b0, rd_ptr_q} == (frame_len_q - (ADDR_W+1)'(1)));

  // Occupancy including a write accepted this cycle; flush decisions use it so
  // a word written together with flush belongs to the closing frame.
  assign count_post = count_q + {{ADDR_W{1'b0}}, wr_hs};

  array_store_regs #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk    (clk),
    .we     (mem_we),
    .waddr  (wr_ptr_q),
    .wdata  (wr_data),
    .raddr  (rd_ptr_q),
    .rdata  (rd_data)
  );

  // Next-state logic for the fill/drain FSM, pointers and accumulator.
  always_comb begin
    state_d           = state_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    frame_len_d       = frame_len_q;
    count_d           = count_q;
    acc_d             = acc_q;
    frame_sum_d       = frame_sum_q;
    frame_sum_valid_d = 1'b0;
    mem_we            = 1'b0;

    case (state_q)
      ST_FILL: begin
        count_d = count_post;
        if (wr_hs) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          acc_d    = acc_q + SUM_W'(wr_data);
        end else begin
          mem_we   = 1'b0;
        end
        if (wr_hs && (count_post == FULL)) begin
          state_d     = ST_DRAIN;
          frame_len_d = FULL;
        end else if (flush && (count_post != (ADDR_W+1)'(0))) begin
          state_d     = ST_DRAIN;
          frame_len_d = count_post;
        end else begin
          state_d     = ST_FILL;
        end
      end

      ST_DRAIN: begin
        if (rd_hs) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          count_d  = count_q - (ADDR_W+1)'(1);
          if (rd_last) begin
            // Frame complete: publish the sum and rearm at address 0.
            frame_sum_d       = acc_q;
            frame_sum_valid_d = 1'b1;
            wr_ptr_d          = {ADDR_W{1'b0}};
            rd_ptr_d          = {ADDR_W{1'b0}};
            acc_d             = {SUM_W{1'b0}};
            frame_len_d       = {(ADDR_W+1){1'b0}};
            state_d           = ST_FILL;
          end else begin
            state_d           = ST_DRAIN;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_FILL;
      wr_ptr_q          <= {ADDR_W{1'b0}};
      rd_ptr_q          <= {ADDR_W{1'b0}};
      frame_len_q       <= {(ADDR_W+1){1'b0}};
      count_q           <= {(ADDR_W+1){1'b0}};
      acc_q             <= {SUM_W{1'b0}};
      frame_sum_q       <= {SUM_W{1'b0}};
      frame_sum_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      frame_len_q       <= frame_len_d;
      count_q           <= count_d;
      acc_q             <= acc_d;
      frame_sum_q       <= frame_sum_d;
      frame_sum_valid_q <= frame_sum_valid_d;
    end
  end

  assign frame_sum       = frame_sum_q;
  assign frame_sum_valid = frame_sum_valid_q;
  assign count           = count_q;

endmodule

// File: tb/tb_array_frame_reader.sv
// Directed self-checking bench for array_frame_reader.
module tb_array_frame_reader;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        flush;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        rd_last;
  logic [10:0] frame_sum;
  logic        frame_sum_valid;
  logic [3:0]  count;

  int vectors;
  int miscompares;
  logic [7:0] wdat [8];

  array_frame_reader dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .flush           (flush),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_ready        (rd_ready),
    .rd_last         (rd_last),
    .frame_sum       (frame_sum),
    .frame_sum_valid (frame_sum_valid),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer wdat[0..n-1]; optionally raise flush with the last word.
  task automatic write_words(input int n, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = wdat[i];
      flush    = flush_last && (i == n - 1);
      chk("wr_ready_fill", 32'(wr_ready), 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Drain n words expecting wdat order; stall applies the 1,0,0 ready pattern.
  task automatic drain(input int n, input logic [10:0] sum, input bit stall);
    int got;
    int cyc;
    logic rr;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 64) begin
      rr = stall ? ((cyc % 3) == 0) : 1'b1;
      rd_ready = rr;
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("wr_ready_drain", 32'(wr_ready), 32'd0);
      chk("rd_data", 32'(rd_data), 32'(wdat[got]));
      chk("rd_last", 32'(rd_last), 32'(got == n - 1));
      chk("count_drain", 32'(count), 32'(n - got));
      tick();
      if (rr) got++;
      cyc++;
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    chk("drain_len", 32'(got), 32'(n));
    chk("sum_valid_pulse", 32'(frame_sum_valid), 32'd1);
    chk("frame_sum", 32'(frame_sum), 32'(sum));
    chk("wr_ready_after", 32'(wr_ready), 32'd1);
    chk("rd_valid_after", 32'(rd_valid), 32'd0);
    chk("count_after", 32'(count), 32'd0);
    tick();
    chk("sum_valid_drop", 32'(frame_sum_valid), 32'd0);
    chk("frame_sum_hold", 32'(frame_sum), 32'(sum));
    chk("count_idle", 32'(count), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_frame_sum", 32'(frame_sum), 32'd0);
    chk("rst_sum_valid", 32'(frame_sum_valid), 32'd0);

    // 1: full frame 0x01..0x08 -> sum 36
    for (int i = 0; i < 8; i++) wdat[i] = 8'(i + 1);
    rd_ready = 1'b1;
    write_words(8, 1'b0);
    chk("t1_wr_ready_drop", 32'(wr_ready), 32'd0);
    chk("t1_count_full", 32'(count), 32'd8);
    drain(8, 11'h024, 1'b0);

    // 2: 0xFF x8 -> 0x7F8, no overflow
    for (int i = 0; i < 8; i++) wdat[i] = 8'hFF;
    write_words(8, 1'b0);
    drain(8, 11'h7F8, 1'b0);

    // 3a: three words then a separate flush
    wdat[0] = 8'h10; wdat[1] = 8'h20; wdat[2] = 8'h30;
    write_words(3, 1'b0);
    chk("t3_still_fill", 32'(wr_ready), 32'd1);
    chk("t3_count3", 32'(count), 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(3, 11'h060, 1'b0);

    // 3b: flush together with the 4th word includes it
    wdat[3] = 8'h40;
    write_words(4, 1'b1);
    drain(4, 11'h0A0, 1'b0);

    // 4: backpressure on a full frame 0x21..0x28 -> 0x124
    for (int i = 0; i < 8; i++) wdat[i] = 8'(8'h21 + 8'(i));
    write_words(8, 1'b0);
    drain(8, 11'h124, 1'b1);

    // 5: writes offered during drain are ignored; flush while empty ignored
    wdat[0] = 8'h01; wdat[1] = 8'h02; wdat[2] = 8'h03;
    write_words(3, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    drain(3, 11'h006, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_empty_wr_ready", 32'(wr_ready), 32'd1);
    chk("t5_flush_empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("t5_flush_empty_count", 32'(count), 32'd0);
    chk("t5_flush_empty_sum_valid", 32'(frame_sum_valid), 32'd0);

    // 6: reset after the third read of a full frame
    for (int i = 0; i < 8; i++) wdat[i] = 8'(i + 1);
    write_words(8, 1'b0);
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_count_mid", 32'(count), 32'd5);
    rd_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rst_rd_last", 32'(rd_last), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_frame_sum", 32'(frame_sum), 32'd0);
    chk("t6_rst_sum_valid", 32'(frame_sum_valid), 32'd0);
    rst = 1'b0;
    tick();
    wdat[0] = 8'h05; wdat[1] = 8'h06;
    write_words(2, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(2, 11'h00B, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
